// File: rtl/instr_mem_loader_if.sv
// Signal bundle between the UART receiver, the program loader and the
// instruction-memory write port. The loader sits on the slave side.
interface instr_mem_loader_if #(
  parameter int LEN     = 32,
  parameter int NB_BYTE = 8,
  parameter int ADDR_W  = 6
);
  // Control and byte stream into the loader
  logic               start;
  logic               rx_done;
  logic [NB_BYTE-1:0] rx_data;

  // Memory write port and status out of the loader
  logic               erase_mem;
  logic               mem_we;
  logic [ADDR_W-1:0]  mem_addr;
  logic [LEN-1:0]     mem_wdata;
  logic               busy;
  logic               done;
  logic [ADDR_W:0]    word_count;
  logic               err_overflow;
  logic               err_timeout;

  modport master (
    output start, rx_done, rx_data,
    input  erase_mem, mem_we, mem_addr, mem_wdata,
    input  busy, done, word_count, err_overflow, err_timeout
  );

  modport slave (
    input  start, rx_done, rx_data,
    output erase_mem, mem_we, mem_addr, mem_wdata,
    output busy, done, word_count, err_overflow, err_timeout
  );
endinterface

// File: rtl/instr_mem_loader.sv
// Program loader: packs UART bytes MSB-first into instruction words and
// writes them to consecutive instruction-memory addresses. A load ends on
// the HALT word (which is itself written) or when the memory is full. A
// partial word whose next byte does not arrive in time is dropped.
// Every output is driven straight from a flop.
module instr_mem_loader #(
  parameter int             LEN       = 32,
  parameter int             NB_BYTE   = 8,
  parameter int             ADDR_W    = 6,
  parameter logic [LEN-1:0] HALT_WORD = 32'hFFFF_FFFF,
  parameter int             TIMEOUT   = 200000
) (
  input  logic               clk,
  input  logic               reset,
  instr_mem_loader_if.slave  bus
);

  // Four bytes per word, so a two-bit lane counter suffices
  localparam int              LAST_LANE = (LEN / NB_BYTE) - 1;
  localparam int              TMO_W     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [1:0]      BC_LAST   = 2'd3;
  localparam logic [1:0]      BC_ONE    = 2'd1;
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_MAX = {ADDR_W{1'b1}};
  localparam logic [ADDR_W:0]   WC_ONE   = (ADDR_W + 1)'(1);
  localparam logic [TMO_W-1:0]  TMO_ONE  = TMO_W'(1);
  localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TIMEOUT - 1);

  // The packing scheme only makes sense for exactly four bytes per word
  if (LEN != 4 * NB_BYTE) begin : g_bad_len
    $error("instr_mem_loader: LEN must equal 4*NB_BYTE");
  end

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ERASE = 3'd1,
    S_RECV  = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  // Place byte number idx (0 = first received) into its MSB-first lane
  function automatic logic [LEN-1:0] put_byte(
    input logic [LEN-1:0]     word,
    input logic [1:0]         idx,
    input logic [NB_BYTE-1:0] b
  );
    logic [LEN-1:0] res;
    int             lane;
    res  = word;
    lane = LAST_LANE - int'(idx);
    res[lane*NB_BYTE +: NB_BYTE] = b;
    return res;
  endfunction

  // State and datapath registers
  state_t            r_state;
  logic [1:0]        r_byte_cnt;
  logic [LEN-1:0]    r_asm;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W:0]   r_word_cnt;
  logic [TMO_W-1:0]  r_tmo;
  logic [LEN-1:0]    r_wdata;
  logic              r_ovf;
  logic              r_tout;
  logic              r_we;
  logic              r_erase;
  logic              r_busy;
  logic              r_done;

  // Next-state values
  state_t            w_state_nxt;
  logic [1:0]        w_byte_cnt;
  logic [LEN-1:0]    w_asm;
  logic [LEN-1:0]    w_asm_ins;
  logic [ADDR_W-1:0] w_addr;
  logic [ADDR_W:0]   w_word_cnt;
  logic [TMO_W-1:0]  w_tmo;
  logic [LEN-1:0]    w_wdata;
  logic              w_ovf;
  logic              w_tout;

  // Next-state and datapath decisions for the load sequence
  always_comb begin
    w_state_nxt = r_state;
    w_byte_cnt  = r_byte_cnt;
    w_asm       = r_asm;
    w_addr      = r_addr;
    w_word_cnt  = r_word_cnt;
    w_tmo       = r_tmo;
    w_wdata     = r_wdata;
    w_ovf       = r_ovf;
    w_tout      = r_tout;
    w_asm_ins   = put_byte(r_asm, r_byte_cnt, bus.rx_data);

    case (r_state)
      S_IDLE: begin
        // Idle keeps every counter and flag clear; bytes are ignored
        w_byte_cnt = '0;
        w_addr     = '0;
        w_word_cnt = '0;
        w_tmo      = '0;
        w_ovf      = 1'b0;
        w_tout     = 1'b0;
        if (bus.start) begin
          w_state_nxt = S_ERASE;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end

      S_ERASE: begin
        // Start every load with an empty assembly register
        w_byte_cnt  = '0;
        w_asm       = '0;
        w_tmo       = '0;
        w_state_nxt = S_RECV;
      end

      S_RECV: begin
        if (bus.rx_done) begin
          w_asm = w_asm_ins;
          w_tmo = '0;
          if (r_byte_cnt == BC_LAST) begin
            w_wdata     = w_asm_ins;
            w_byte_cnt  = '0;
            w_state_nxt = S_WRITE;
          end else begin
            w_byte_cnt = r_byte_cnt + BC_ONE;
          end
        end else if (r_byte_cnt != 2'd0) begin
          // A stalled partial word is dropped rather than merged with later bytes
          if (r_tmo == TMO_LAST) begin
            w_byte_cnt = '0;
            w_asm      = '0;
            w_tmo      = '0;
            w_tout     = 1'b1;
          end else begin
            w_tmo = r_tmo + TMO_ONE;
          end
        end else begin
          w_tmo = '0;
        end
      end

      S_WRITE: begin
        w_addr     = r_addr + ADDR_ONE;
        w_word_cnt = r_word_cnt + WC_ONE;
        w_tmo      = '0;
        // A byte arriving right behind the 4th one opens the next word;
        // it goes to the assembly register so mem_wdata stays stable
        if (bus.rx_done) begin
          w_asm      = w_asm_ins;
          w_byte_cnt = BC_ONE;
        end else begin
          w_byte_cnt = r_byte_cnt;
        end
        if (r_wdata == HALT_WORD) begin
          w_state_nxt = S_DONE;
        end else if (r_addr == ADDR_MAX) begin
          w_state_nxt = S_DONE;
          w_ovf       = 1'b1;
        end else begin
          w_state_nxt = S_RECV;
        end
      end

      S_DONE: begin
        // Re-arming clears the previous load's results before ERASE shows
        if (bus.start) begin
          w_state_nxt = S_ERASE;
          w_byte_cnt  = '0;
          w_addr      = '0;
          w_word_cnt  = '0;
          w_tmo       = '0;
          w_ovf       = 1'b0;
          w_tout      = 1'b0;
        end else begin
          w_state_nxt = S_DONE;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State, datapath and registered strobes, all cleared by reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_byte_cnt <= '0;
      r_asm      <= '0;
      r_addr     <= '0;
      r_word_cnt <= '0;
      r_tmo      <= '0;
      r_wdata    <= '0;
      r_ovf      <= 1'b0;
      r_tout     <= 1'b0;
      r_we       <= 1'b0;
      r_erase    <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_byte_cnt <= w_byte_cnt;
      r_asm      <= w_asm;
      r_addr     <= w_addr;
      r_word_cnt <= w_word_cnt;
      r_tmo      <= w_tmo;
      r_wdata    <= w_wdata;
      r_ovf      <= w_ovf;
      r_tout     <= w_tout;
      r_we       <= (w_state_nxt == S_WRITE);
      r_erase    <= (w_state_nxt == S_ERASE);
      r_busy     <= (w_state_nxt == S_ERASE) || (w_state_nxt == S_RECV) ||
                    (w_state_nxt == S_WRITE);
      r_done     <= (w_state_nxt == S_DONE);
    end
  end

  assign bus.erase_mem    = r_erase;
  assign bus.mem_we       = r_we;
  assign bus.mem_addr     = r_addr;
  assign bus.mem_wdata    = r_wdata;
  assign bus.busy         = r_busy;
  assign bus.done         = r_done;
  assign bus.word_count   = r_word_cnt;
  assign bus.err_overflow = r_ovf;
  assign bus.err_timeout  = r_tout;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Bench for instr_mem_loader: directed scenarios plus random loads, all
// compared against a transaction-level model of the load rules.
module tb_instr_mem_loader;
  localparam int          LEN  = 32;
  localparam int          NB   = 8;
  localparam int          AW   = 2;
  localparam int          TMO  = 16;
  localparam logic [31:0] HALT = 32'hFFFF_FFFF;

  logic clk;
  logic reset;

  instr_mem_loader_if #(.LEN(LEN), .NB_BYTE(NB), .ADDR_W(AW)) bus ();

  instr_mem_loader #(
    .LEN(LEN), .NB_BYTE(NB), .ADDR_W(AW), .HALT_WORD(HALT), .TIMEOUT(TMO)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [AW-1:0] a;
    logic [31:0]   d;
    int            c;
  } wr_t;

  wr_t act_q[$];
  wr_t exp_q[$];
  int  erase_cnt = 0;
  int  tout_rise = -1;
  logic tout_prev = 1'b0;

  // Monitor: sample outputs mid-cycle and log writes, erases, timeout rise
  always @(negedge clk) begin : mon
    wr_t w;
    if (bus.mem_we) begin
      w.a = bus.mem_addr;
      w.d = bus.mem_wdata;
      w.c = cyc;
      act_q.push_back(w);
    end
    if (bus.erase_mem) erase_cnt = erase_cnt + 1;
    if (bus.err_timeout && !tout_prev) tout_rise = cyc;
    tout_prev = bus.err_timeout;
  end

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  bit          m_active = 0;
  bit          m_done   = 0;
  bit          m_ovf    = 0;
  bit          m_tout   = 0;
  int          m_n      = 0;
  int          m_count  = 0;
  int          m_last   = 0;
  logic [31:0] m_word   = 32'd0;
  int          exp_erase = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_active = 0; m_done = 0; m_ovf = 0; m_tout = 0; m_n = 0; m_count = 0;
  endtask

  // A partial word is lost once TMO byte-free cycles have passed since its last byte
  task automatic model_settle();
    if (m_active && m_n > 0 && cyc >= m_last + TMO) begin
      m_n = 0;
      m_tout = 1;
    end
  endtask

  task automatic model_byte(input int e, input logic [7:0] b);
    wr_t x;
    if (!m_active) return;
    if (m_n > 0 && (e - m_last) > TMO) begin
      m_n = 0;
      m_tout = 1;
    end
    m_word = {m_word[23:0], b};
    m_n++;
    m_last = e;
    if (m_n == 4) begin
      x.a = AW'(m_count);
      x.d = m_word;
      x.c = e;
      exp_q.push_back(x);
      m_count++;
      m_n = 0;
      if (m_word == HALT) begin
        m_active = 0; m_done = 1;
      end else if (m_count == (1 << AW)) begin
        m_active = 0; m_done = 1; m_ovf = 1;
      end
    end
  endtask

  task automatic send_byte(input int gap, input logic [7:0] b);
    int e;
    repeat (gap) tick();
    bus.rx_done = 1'b1;
    bus.rx_data = b;
    e = cyc + 1;
    tick();
    bus.rx_done = 1'b0;
    model_byte(e, b);
  endtask

  task automatic send_word(input int gap, input logic [31:0] w);
    send_byte(gap, w[31:24]);
    send_byte(0, w[23:16]);
    send_byte(0, w[15:8]);
    send_byte(0, w[7:0]);
  endtask

  task automatic do_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    if (!m_active) begin
      m_active = 1; m_done = 0; m_n = 0; m_count = 0; m_ovf = 0; m_tout = 0;
      exp_erase++;
    end
    tick();
    chk("start.erase_cnt", erase_cnt, exp_erase);
  endtask

  task automatic check_writes(input string tag);
    wr_t a, x;
    chk({tag, ".nwr"}, act_q.size(), exp_q.size());
    while (act_q.size() > 0 && exp_q.size() > 0) begin
      a = act_q.pop_front();
      x = exp_q.pop_front();
      chk({tag, ".addr"}, a.a, x.a);
      chk({tag, ".data"}, a.d, x.d);
      chk({tag, ".cycle"}, a.c, x.c);
    end
    act_q.delete();
    exp_q.delete();
  endtask

  task automatic check_status(input string tag);
    model_settle();
    chk({tag, ".done"}, bus.done, m_done);
    chk({tag, ".busy"}, bus.busy, m_active);
    chk({tag, ".wc"}, bus.word_count, m_count);
    chk({tag, ".ovf"}, bus.err_overflow, m_ovf);
    chk({tag, ".tout"}, bus.err_timeout, m_tout);
  endtask

  task automatic finish_load(input string tag);
    repeat (3) tick();
    check_writes(tag);
    check_status(tag);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, ".erase"}, bus.erase_mem, 1'b0);
    chk({tag, ".we"}, bus.mem_we, 1'b0);
    chk({tag, ".addr"}, bus.mem_addr, 2'd0);
    chk({tag, ".wdata"}, bus.mem_wdata, 32'd0);
    chk({tag, ".busy"}, bus.busy, 1'b0);
    chk({tag, ".done"}, bus.done, 1'b0);
    chk({tag, ".wc"}, bus.word_count, 3'd0);
    chk({tag, ".ovf"}, bus.err_overflow, 1'b0);
    chk({tag, ".tout"}, bus.err_timeout, 1'b0);
  endtask

  function automatic int rand_gap();
    int r;
    r = $urandom_range(0, 9);
    if (r == 6) return TMO - 1;
    if (r == 7) return TMO;
    if (r == 8) return TMO + 2;
    if (r == 9) return 0;
    return $urandom_range(0, 2);
  endfunction

  initial begin
    int l_edge;
    int e0;
    int nw;
    logic [31:0] w;

    bus.start = 1'b0; bus.rx_done = 1'b0; bus.rx_data = 8'h00;
    reset = 1'b0;
    repeat (3) tick();
    check_zero("reset");
    reset = 1'b1;
    repeat (2) tick();
    check_zero("idle");

    // Normal load, HALT lands on the last address without overflow
    do_start();
    send_word(0, 32'h2001_0005);
    chk("t1.busy_mid", bus.busy, 1'b1);
    send_word(0, 32'h2002_0007);
    send_word(2, 32'h0022_1820);
    send_word(1, HALT);
    finish_load("t1");

    // Overflow: memory fills, fifth word is dropped
    do_start();
    for (int i = 0; i < 5; i++) begin
      w = $urandom;
      w[31] = 1'b0;
      send_word($urandom_range(0, 2), w);
    end
    finish_load("t2");

    // Timeout of a two-byte partial word
    do_start();
    send_byte(0, 8'hAA);
    send_byte(0, 8'hBB);
    l_edge = m_last;
    send_word(20, 32'h1122_3344);
    chk("t3.tout_edge", tout_rise, l_edge + TMO);
    repeat (2) tick();
    check_writes("t3");
    check_status("t3");

    // Start pulses in RECV and WRITE are ignored
    e0 = erase_cnt;
    bus.start = 1'b1; tick(); bus.start = 1'b0;
    repeat (2) tick();
    chk("t6.recv_start", erase_cnt, e0);
    check_status("t6a");
    send_byte(0, 8'h0B); send_byte(0, 8'hAD); send_byte(0, 8'hF0); send_byte(0, 8'h0D);
    bus.start = 1'b1; tick(); bus.start = 1'b0;
    repeat (2) tick();
    chk("t6.write_start", erase_cnt, e0);
    check_writes("t6b");
    check_status("t6b");
    send_word(0, HALT);
    finish_load("t6c");
    do_start();
    check_status("t6d");

    // Back-to-back: byte during WRITE starts the next word
    send_word(0, 32'h1234_5678);
    send_word(0, 32'hDEAD_BEEF);
    send_word(3, HALT);
    finish_load("t4");

    // Reset with two words written and two bytes pending
    do_start();
    send_word(0, 32'h0101_0101);
    send_word(1, 32'h0202_0202);
    send_byte(0, 8'h33);
    send_byte(0, 8'h44);
    repeat (2) tick();
    check_writes("t5pre");
    #2 reset = 1'b0;
    #1 check_zero("t5rst");
    model_reset();
    tick(); tick();
    reset = 1'b1;
    tick();
    check_zero("t5rel");
    do_start();
    send_word(0, HALT);
    finish_load("t5");

    // Random loads
    for (int k = 0; k < 20; k++) begin
      do_start();
      nw = $urandom_range(1, 6);
      for (int j = 0; j < nw; j++) begin
        w = ($urandom_range(0, 7) == 0) ? HALT : $urandom;
        for (int bi = 3; bi >= 0; bi--) begin
          send_byte(rand_gap(), w[bi*8 +: 8]);
        end
      end
      finish_load("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/instr_mem_loader.md
Name: instr_mem_loader

Overview:
- Upstream feeder for the instruction-fetch stage's program memory.
- Collects bytes from the UART receiver and assembles them into 32-bit instructions, then writes them to sequential instruction-memory addresses.
- Stops on a HALT word or when memory is full, then reports completion to the debug state machine.
- Sits between the uart rx_done/data_out outputs and the instruction memory write port.

Parameters:
LEN, 32, instruction width in bits; must be 4*NB_BYTE
NB_BYTE, 8, UART byte width
ADDR_W, 6, instruction-memory address width (64 words)
HALT_WORD, 32'hFFFF_FFFF, instruction that terminates a load; it is itself written
TIMEOUT, 200000, clk cycles allowed between bytes of one partial word before that word is discarded

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
start  in  1  single-cycle pulse that arms a new load
rx_done  in  1  single-cycle strobe from UART; rx_data valid on this cycle
rx_data  in  NB_BYTE  received byte
erase_mem  out  1  single-cycle pulse instructing instruction memory to clear
mem_we  out  1  instruction-memory write enable
mem_addr  out  ADDR_W  write address
mem_wdata  out  LEN  write data
busy  out  1  high from ERASE through the final WRITE
done  out  1  held high in DONE
word_count  out  ADDR_W+1  words written in current load, including HALT
err_overflow  out  1  sticky: memory filled without HALT
err_timeout  out  1  sticky: partial word discarded

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE
  - all outputs 0
  - byte counter, address counter, timeout counter and shift register cleared
- States: IDLE, ERASE, RECV, WRITE, DONE.
- IDLE:
  - start=1 → ERASE.
  - Clears word_count, address counter, byte counter and both error flags.
  - rx_done is ignored.
- ERASE:
  - Lasts exactly one cycle with erase_mem=1, busy=1.
  - Next state is RECV.
- RECV:
  - On rx_done, rx_data shifts into the assembly register MSB-first: first byte lands in [31:24], fourth byte in [7:0].
  - byte_cnt increments 0..3.
  - On the cycle that accepts the 4th byte, the full word is latched into mem_wdata, byte_cnt wraps to 0, and the next state is WRITE.
- WRITE:
  - Lasts exactly one cycle with mem_we=1, mem_addr=addr_cnt and mem_wdata stable.
  - At exit, addr_cnt and word_count increment.
  - Next state:
    - mem_wdata==HALT_WORD → DONE (HALT takes priority over overflow);
    - else addr_cnt==2^ADDR_W-1 → DONE with err_overflow=1;
    - else → RECV.
  - An rx_done arriving in WRITE is not lost. The byte is accepted as byte 0 of the next word and does not disturb mem_wdata.
- Timeout:
  - In RECV with byte_cnt≠0, the counter increments each cycle without rx_done and resets on rx_done.
  - When the counter reaches TIMEOUT: byte_cnt←0, partial data discarded, err_timeout←1, state stays RECV, no write.
  - The counter is held at 0 when byte_cnt==0.
- DONE:
  - done=1, busy=0, mem_we=0.
  - word_count and error flags hold; rx_done is ignored.
  - start=1 → ERASE, which clears word_count, errors and addr_cnt.
- start in ERASE, RECV or WRITE is ignored.
- mem_we is never asserted outside WRITE. erase_mem is never asserted outside ERASE.
- Latency: mem_we rises exactly 1 cycle after the rx_done carrying the 4th byte.
- Reset asserted mid-load aborts immediately. No write completes after reset falls.

Test Plan:
1. Normal load:
   - Stimulus: start, then bytes 20 01 00 05, 20 02 00 07, 00 22 18 20, FF FF FF FF.
   - Response: erase_mem pulses once; four writes with addr 0..3 and data 0x20010005, 0x20020007, 0x00221820, 0xFFFFFFFF; each mem_we exactly 1 cycle after the 4th rx_done; done=1, word_count=4, no errors.
2. Overflow:
   - Stimulus: ADDR_W=2, four non-HALT words, then a 5th word.
   - Response: writes at addr 0..3; done=1, err_overflow=1, word_count=4; 5th word's bytes produce no write.
3. Timeout:
   - Stimulus: TIMEOUT=16, bytes AA BB, then 20 idle cycles, then 11 22 33 44.
   - Response: err_timeout=1 exactly 16 cycles after BB; no write for AA BB; one write addr 0 data 0x11223344.
4. Back-to-back bytes:
   - Stimulus: 4th byte of word 0 followed next cycle (during WRITE) by rx_done with 0xDE, then 0xAD 0xBE 0xEF.
   - Response: word 0 is written unchanged; second write addr 1 data 0xDEADBEEF.
5. Reset mid-load:
   - Stimulus: assert reset after two words are written and with 2 bytes pending, release, start, then one HALT word.
   - Response: all outputs 0 asynchronously during reset; after restart the HALT is written at addr 0, word_count=1.
6. Start handling:
   - Stimulus: start pulses during RECV and WRITE, then start in DONE.
   - Response: pulses in RECV and WRITE have no effect (no erase_mem, counters unchanged); start in DONE re-erases and clears word_count and error flags.
